cpu_control: RTL

Multicycle control state machine for the RV32I CPU datapath. Each cycle it decodes `opcode`/`funct3`/`funct7`/`br_en` from the datapath and drives every datapath mux select and register load. It also runs the memory read/write handshake toward the cache for instruction fetch, loads and stores. It sits beside the datapath inside the CPU top and is the only source of datapath control.

---
 rtl/cpu_control.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_control.sv
// Multicycle RV32I control FSM: decodes the IR and sequences the datapath and memory handshake.
// Optional: define CPU_CONTROL_HALT_ON_ILLEGAL_EN to make illegal opcodes halt until reset.
package cpu_control_pkg;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        f3_add, f3_sll, f3_slt, f3_sltu, f3_xor, f3_sr, f3_or, f3_and
    } arith_funct3_t;

    typedef enum logic [2:0] {
        lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000, sh = 3'b001, sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
    } alu_ops;

    typedef enum logic [1:0] {
        pcmux_pc_plus4, pcmux_alu_out, pcmux_alu_mod2
    } pcmux_sel_t;

    typedef enum logic {
        alumux1_rs1_out, alumux1_pc_out
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm, alumux2_u_imm, alumux2_b_imm,
        alumux2_s_imm, alumux2_j_imm, alumux2_rs2_out
    } alumux2_sel_t;

    typedef enum logic [3:0] {
        rf_alu_out, rf_br_en, rf_u_imm, rf_lw, rf_pc_plus4,
        rf_lb, rf_lbu, rf_lh, rf_lhu
    } regfilemux_sel_t;

    typedef enum logic {
        marmux_pc_out, marmux_alu_out
    } marmux_sel_t;

    typedef enum logic {
        cmpmux_rs2_out, cmpmux_i_imm
    } cmpmux_sel_t;
endpackage

module cpu_control
    import cpu_control_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  rv32i_opcode     opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            br_en,
    input  logic [1:0]      mem_addr_offset,
    input  logic            mem_resp,
    output logic            mem_read,
    output logic            mem_write,
    output logic [3:0]      mem_byte_enable,
    output pcmux_sel_t      pcmux_sel,
    output alumux1_sel_t    alumux1_sel,
    output alumux2_sel_t    alumux2_sel,
    output regfilemux_sel_t regfilemux_sel,
    output marmux_sel_t     marmux_sel,
    output cmpmux_sel_t     cmpmux_sel,
    output alu_ops          aluop,
    output branch_funct3_t  cmpop,
    output logic            load_pc,
    output logic            load_ir,
    output logic            load_regfile,
    output logic            load_mar,
    output logic            load_mdr,
    output logic            load_data_out,
    output logic            halted
);
    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_IMM, S_REG, S_LUI, S_AUIPC, S_BR, S_JAL, S_JALR,
        S_CALC_LD, S_LD1, S_LD2, S_CALC_ST, S_ST1, S_ILLEGAL
    } state_t;

    state_t state_q, state_d;

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH1;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'b1111;
        pcmux_sel       = pcmux_pc_plus4;
        alumux1_sel     = alumux1_rs1_out;
        alumux2_sel     = alumux2_i_imm;
        regfilemux_sel  = rf_alu_out;
        marmux_sel      = marmux_pc_out;
        cmpmux_sel      = cmpmux_rs2_out;
        aluop           = alu_add;
        cmpop           = beq;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        halted          = 1'b0;
        // Reset masks everything, including any in-flight strobe.
        if (!rst) begin
            unique case (state_q)
                S_FETCH1: begin
                    load_mar = 1'b1;
                    state_d  = S_FETCH2;
                end
                S_FETCH2: begin
                    mem_read = 1'b1;
                    if (mem_resp) begin
                        load_mdr = 1'b1;
                        state_d  = S_FETCH3;
                    end
                end
                S_FETCH3: begin
                    load_ir = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    unique case (opcode)
                        op_imm:   state_d = S_IMM;
                        op_reg:   state_d = S_REG;
                        op_lui:   state_d = S_LUI;
                        op_auipc: state_d = S_AUIPC;
                        op_br:    state_d = S_BR;
                        op_jal:   state_d = S_JAL;
                        op_jalr:  state_d = S_JALR;
                        op_load:  state_d = S_CALC_LD;
                        op_store: state_d = S_CALC_ST;
                        default:  state_d = S_ILLEGAL;
                    endcase
                end
                S_IMM, S_REG: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    state_d      = S_FETCH1;
                    aluop        = alu_ops'(funct3);
                    if (state_q == S_REG) alumux2_sel = alumux2_rs2_out;
                    if (funct3 == f3_sr && funct7[5]) aluop = alu_sra;
                    if (state_q == S_REG && funct3 == f3_add && funct7[5])
                        aluop = alu_sub;
                    if (funct3 == f3_slt || funct3 == f3_sltu) begin
                        regfilemux_sel = rf_br_en;
                        cmpop = (funct3 == f3_slt) ? blt : bltu;
                        if (state_q == S_IMM) cmpmux_sel = cmpmux_i_imm;
                    end
                end
                S_LUI: begin
                    regfilemux_sel = rf_u_imm;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = S_FETCH1;
                end
                S_AUIPC: begin
                    alumux1_sel  = alumux1_pc_out;
                    alumux2_sel  = alumux2_u_imm;
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    state_d      = S_FETCH1;
                end
                S_BR: begin
                    alumux1_sel = alumux1_pc_out;
                    alumux2_sel = alumux2_b_imm;
                    cmpop       = branch_funct3_t'(funct3);
                    pcmux_sel   = br_en ? pcmux_alu_out : pcmux_pc_plus4;
                    load_pc     = 1'b1;
                    state_d     = S_FETCH1;
                end
                S_JAL: begin
                    alumux1_sel    = alumux1_pc_out;
                    alumux2_sel    = alumux2_j_imm;
                    pcmux_sel      = pcmux_alu_out;
                    regfilemux_sel = rf_pc_plus4;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = S_FETCH1;
                end
                S_JALR: begin
                    pcmux_sel      = pcmux_alu_mod2;
                    regfilemux_sel = rf_pc_plus4;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = S_FETCH1;
                end
                S_CALC_LD: begin
                    marmux_sel = marmux_alu_out;
                    load_mar   = 1'b1;
                    state_d    = S_LD1;
                end
                S_LD1: begin
                    mem_read = 1'b1;
                    if (mem_resp) begin
                        load_mdr = 1'b1;
                        state_d  = S_LD2;
                    end
                end
                S_LD2: begin
                    unique case (funct3)
                        lb:      regfilemux_sel = rf_lb;
                        lh:      regfilemux_sel = rf_lh;
                        lbu:     regfilemux_sel = rf_lbu;
                        lhu:     regfilemux_sel = rf_lhu;
                        default: regfilemux_sel = rf_lw;
                    endcase
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    state_d      = S_FETCH1;
                end
                S_CALC_ST: begin
                    alumux2_sel   = alumux2_s_imm;
                    marmux_sel    = marmux_alu_out;
                    load_mar      = 1'b1;
                    load_data_out = 1'b1;
                    state_d       = S_ST1;
                end
                S_ST1: begin
                    mem_write = 1'b1;
                    unique case (funct3)
                        sb:      mem_byte_enable = 4'b0001 << mem_addr_offset;
                        sh:      mem_byte_enable = 4'b0011 << mem_addr_offset;
                        default: mem_byte_enable = 4'b1111;
                    endcase
                    if (mem_resp) begin
                        load_pc = 1'b1;
                        state_d = S_FETCH1;
                    end
                end
                S_ILLEGAL: begin
`ifdef CPU_CONTROL_HALT_ON_ILLEGAL_EN
                    halted = 1'b1;
`else
                    load_pc = 1'b1;
                    state_d = S_FETCH1;
`endif
                end
                default: state_d = S_FETCH1;
            endcase
        end
    end
endmodule
